// File: rtl/abc_eval_pkg.sv
// Shared types and the golden model for the abc evaluation sequencer.
package abc_eval_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, FIN} state_t;

    localparam logic [2:0] VEC_LAST = 3'd7;

    // abc = {a,b,c}; y = ~b & (~c | a)
    function automatic logic golden_y(input logic [2:0] abc);
        return ~abc[1] & (~abc[0] | abc[2]);
    endfunction

endpackage

// File: rtl/abc_eval_sequencer_sync_ff.sv
// Reset-to-0 multi-flop synchroniser for the asynchronous y input.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[STAGES-2:0], d};
        end
    end

    assign q = sr_q[STAGES-1];

endmodule

// File: rtl/abc_eval_sequencer.sv
// Drives {a,b,c} into the function block, waits for y to settle, samples it
// through a synchroniser and scores it against the golden value.
module abc_eval_sequencer
    import abc_eval_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       single,
    input  logic [2:0] vec_in,
    input  logic       abort,
    input  logic       y_in,
    output logic [2:0] drive_abc,
    output logic       busy,
    output logic       sample_valid,
    output logic [2:0] sample_vec,
    output logic       sample_y,
    output logic       sample_exp,
    output logic       sample_err,
    output logic       unstable,
    output logic [3:0] err_count,
    output logic       done,
    output logic       pass
);

    if (SETTLE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_param
        $error("abc_eval_sequencer: SETTLE_CYCLES must be >=1 and SYNC_STAGES >=2");
    end

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    // The new drive value needs this many window cycles to reach the
    // synchroniser output; edges inside it are the expected response, not instability.
    localparam int unsigned MASK_CYCLES = SYNC_STAGES + 1;

    state_t          state_q;
    logic [2:0]      vec_q;
    logic            single_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   retry_q;
    logic            unst_q;
    logic            y_prev_q;
    logic            y_sync;
    logic            y_change_d;
    logic            samp_err_d;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (y_in),
        .q     (y_sync)
    );

    always_comb begin
        y_change_d = (y_sync != y_prev_q) &&
                     !(retry_q == '0 && 32'(cnt_q) < MASK_CYCLES);
        samp_err_d = (y_sync != golden_y(vec_q)) | unst_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            single_q     <= 1'b0;
            cnt_q        <= '0;
            retry_q      <= '0;
            unst_q       <= 1'b0;
            y_prev_q     <= 1'b0;
            drive_abc    <= '0;
            sample_valid <= 1'b0;
            sample_vec   <= '0;
            sample_y     <= 1'b0;
            sample_exp   <= 1'b0;
            sample_err   <= 1'b0;
            unstable     <= 1'b0;
            err_count    <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            y_prev_q     <= y_sync;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            if (abort) begin
                state_q   <= IDLE;
                drive_abc <= '0;
                unst_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: if (start) begin
                        state_q   <= DRIVE;
                        vec_q     <= single ? vec_in : '0;
                        single_q  <= single;
                        err_count <= '0;
                        pass      <= 1'b0;
                    end
                    DRIVE: begin
                        drive_abc <= vec_q;
                        cnt_q     <= '0;
                        retry_q   <= '0;
                        unst_q    <= 1'b0;
                        state_q   <= SETTLE;
                    end
                    SETTLE: begin
                        if (y_change_d) begin
                            if (retry_q == RW'(MAX_RETRY)) begin
                                unst_q  <= 1'b1;
                                state_q <= SAMPLE;
                            end else begin
                                retry_q <= retry_q + RW'(1);
                                cnt_q   <= '0;
                            end
                        end else if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                            state_q <= SAMPLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    SAMPLE: begin
                        sample_valid <= 1'b1;
                        sample_vec   <= vec_q;
                        sample_y     <= y_sync;
                        sample_exp   <= golden_y(vec_q);
                        sample_err   <= samp_err_d;
                        unstable     <= unst_q;
                        err_count    <= err_count + {3'b000, samp_err_d};
                        if (single_q || vec_q == VEC_LAST) begin
                            state_q <= FIN;
                        end else begin
                            vec_q   <= vec_q + 3'd1;
                            state_q <= DRIVE;
                        end
                    end
                    FIN: begin
                        done    <= 1'b1;
                        pass    <= (err_count == '0);
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_abc_eval_sequencer.sv
// Directed self-checking bench for abc_eval_sequencer.
module tb_abc_eval_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, single, abort, y_in;
    logic [2:0] vec_in, drive_abc, sample_vec;
    logic       busy, sample_valid, sample_y, sample_exp, sample_err, unstable, done, pass;
    logic [3:0] err_count;

    int checks = 0;
    int errors = 0;

    // y model of the function block: 0 = golden after 7 ns, 1 = constant, 2 = toggling
    logic [1:0] ymode = 2'd0;
    logic       yconst = 1'b0;
    logic       y_gold = 1'b1;
    logic       y_tog = 1'b0;

    always #5 clk = ~clk;
    always @(drive_abc) y_gold <= #7 (~drive_abc[1] & (~drive_abc[0] | drive_abc[2]));
    always @(negedge clk) y_tog <= ~y_tog;
    assign y_in = (ymode == 2'd0) ? y_gold : (ymode == 2'd1) ? yconst : y_tog;

    abc_eval_sequencer #(.SETTLE_CYCLES(8), .SYNC_STAGES(2), .MAX_RETRY(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .single(single), .vec_in(vec_in),
        .abort(abort), .y_in(y_in), .drive_abc(drive_abc), .busy(busy),
        .sample_valid(sample_valid), .sample_vec(sample_vec), .sample_y(sample_y),
        .sample_exp(sample_exp), .sample_err(sample_err), .unstable(unstable),
        .err_count(err_count), .done(done), .pass(pass)
    );

    int         nsamp;
    logic [2:0] s_vec  [16];
    logic       s_exp  [16];
    logic       s_err  [16];
    logic       s_y    [16];
    logic       s_unst [16];
    logic [7:0] exp_tbl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_start(input logic sgl, input logic [2:0] v);
        @(negedge clk);
        start = 1'b1; single = sgl; vec_in = v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic record();
        if (sample_valid && nsamp < 16) begin
            s_vec[nsamp] = sample_vec; s_exp[nsamp] = sample_exp; s_err[nsamp] = sample_err;
            s_y[nsamp] = sample_y; s_unst[nsamp] = unstable;
            nsamp++;
        end
    endtask

    task automatic run_watch(input int maxc, output int dcyc);
        dcyc = -1;
        nsamp = 0;
        for (int n = 1; n <= maxc; n++) begin
            @(posedge clk); #1;
            record();
            if (done) begin
                dcyc = n;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int dcyc, dcnt, scnt;
        exp_tbl = 8'b0011_0001;
        rst_n = 1'b0; start = 1'b0; single = 1'b0; vec_in = '0; abort = 1'b0;
        #23;
        chk("reset_busy", busy, 0);
        chk("reset_drive", drive_abc, 0);
        chk("reset_errcnt", err_count, 0);
        chk("reset_done_pass", {done, pass, sample_valid}, 0);
        @(negedge clk); rst_n = 1'b1;
        idle(4);

        // 1: sweep with golden y
        do_start(1'b0, 3'd0);
        run_watch(200, dcyc);
        chk("t1_done_cycle", dcyc, 81);
        chk("t1_nsamp", nsamp, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_vec%0d", i), s_vec[i], i);
            chk($sformatf("t1_exp%0d", i), s_exp[i], exp_tbl[i]);
            chk($sformatf("t1_err%0d", i), s_err[i], 0);
        end
        chk("t1_errcnt", err_count, 0);
        chk("t1_pass", pass, 1);
        chk("t1_busy", busy, 0);

        // 2: sweep with y stuck at 0
        ymode = 2'd1; yconst = 1'b0;
        idle(4);
        do_start(1'b0, 3'd0);
        run_watch(200, dcyc);
        chk("t2_done_cycle", dcyc, 81);
        chk("t2_nsamp", nsamp, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_err%0d", i), s_err[i], exp_tbl[i]);
        chk("t2_errcnt", err_count, 3);
        chk("t2_pass", pass, 0);

        // 3: single vector 101 with y = 1
        yconst = 1'b1;
        idle(4);
        do_start(1'b1, 3'b101);
        run_watch(100, dcyc);
        chk("t3_done_cycle", dcyc, 11);
        chk("t3_nsamp", nsamp, 1);
        chk("t3_vec", s_vec[0], 3'b101);
        chk("t3_exp", s_exp[0], 1);
        chk("t3_y", s_y[0], 1);
        chk("t3_err", s_err[0], 0);
        chk("t3_pass", pass, 1);

        // 4: single vector with y toggling every cycle
        ymode = 2'd2;
        do_start(1'b1, 3'b000);
        run_watch(100, dcyc);
        chk("t4_finished", (dcyc > 0), 1);
        chk("t4_nsamp", nsamp, 1);
        chk("t4_unstable", s_unst[0], 1);
        chk("t4_err", s_err[0], 1);
        chk("t4_errcnt", err_count, 1);
        chk("t4_pass", pass, 0);

        // 5: abort during SETTLE of vec 3, then a full sweep
        ymode = 2'd0;
        idle(4);
        do_start(1'b0, 3'd0);
        for (int n = 1; n <= 34; n++) begin
            @(posedge clk); #1;
        end
        chk("t5_drive_pre", drive_abc, 3);
        chk("t5_busy_pre", busy, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t5_busy_post", busy, 0);
        chk("t5_drive_post", drive_abc, 0);
        dcnt = 0; scnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
            if (sample_valid) scnt++;
        end
        chk("t5_no_done", dcnt, 0);
        chk("t5_no_sample", scnt, 0);
        chk("t5_pass", pass, 0);
        chk("t5_errcnt", err_count, 0);
        @(negedge clk); start = 1'b1; abort = 1'b1; single = 1'b0;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        chk("t5_start_abort", busy, 0);
        do_start(1'b0, 3'd0);
        run_watch(200, dcyc);
        chk("t5_resweep_cycle", dcyc, 81);
        chk("t5_resweep_pass", pass, 1);

        // 6a: start while busy is ignored
        do_start(1'b1, 3'b100);
        dcnt = 0; dcyc = -1; nsamp = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (n == 4) begin start = 1'b1; single = 1'b0; vec_in = 3'b000; end
            if (n == 5) start = 1'b0;
            record();
            if (done) begin dcnt++; dcyc = n; end
        end
        chk("t6_done_count", dcnt, 1);
        chk("t6_done_cycle", dcyc, 11);
        chk("t6_nsamp", nsamp, 1);
        chk("t6_vec", s_vec[0], 3'b100);
        chk("t6_busy", busy, 0);

        // 6b: reset asserted in the SAMPLE cycle of vec 5
        ymode = 2'd1; yconst = 1'b0;
        idle(4);
        do_start(1'b0, 3'd0);
        for (int n = 1; n <= 59; n++) begin
            @(posedge clk); #1;
        end
        chk("t6_drive_pre", drive_abc, 5);
        chk("t6_errcnt_pre", err_count, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_drive", drive_abc, 0);
        chk("t6_rst_errcnt", err_count, 0);
        chk("t6_rst_sample", {sample_valid, sample_vec, sample_y, sample_exp, sample_err, unstable}, 0);
        chk("t6_rst_done_pass", {done, pass}, 0);
        @(negedge clk); rst_n = 1'b1;
        dcnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        chk("t6_idle_after_reset", dcnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
